// File: rtl/bus_memory_responder.sv
// bus_memory_responder: single-outstanding request/ready target with an
// internal word-addressed, byte-maskable RAM.
// Accepts one read or masked write, answers with a one-cycle o_ready pulse
// LATENCY cycles after acceptance, then waits for the request to drop.
// Optional feature macro: BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
//   defined   -> addresses >= SIZE complete without RAM access and pulse o_error
//   undefined -> no o_error port, addresses wrap modulo SIZE
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for i_request; captures the transaction on acceptance
// S_WAIT    | latency countdown; a dropped request abandons the transaction
// S_READY   | one-cycle completion (o_ready = 1); RAM access done on entry
// S_RELEASE | completed, waiting for the initiator to drop i_request

module bus_memory_responder #(
    parameter int SIZE          = 1024,
    parameter int ADDRESS_WIDTH = 32,
    parameter int LATENCY       = 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_request,
    input  logic                     i_rw,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [31:0]              i_wdata,
    input  logic [3:0]               i_wmask,
    output logic                     o_ready,
    output logic [31:0]              o_rdata,
    output logic                     o_busy
`ifdef BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
    ,
    output logic                     o_error
`endif
);

    localparam int IDX_W = $clog2(SIZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_READY   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]               count;
    logic                     cap_rw;
    logic [ADDRESS_WIDTH-1:0] cap_address;
    logic [31:0]              cap_wdata;
    logic [3:0]               cap_wmask;

    logic [31:0] mem [SIZE];

    // With LATENCY = 1 the RAM access happens on the acceptance edge itself,
    // so the live bus inputs are used in IDLE and the captured copy otherwise.
    logic                     acc_rw;
    logic [ADDRESS_WIDTH-1:0] acc_address;
    logic [31:0]              acc_wdata;
    logic [3:0]               acc_wmask;
    logic [IDX_W-1:0]         acc_idx;
    logic                     acc_ok;
    logic                     enter_ready;
    logic                     mem_we;

    // select live or captured transaction fields for the RAM access
    always_comb begin
        acc_rw      = cap_rw;
        acc_address = cap_address;
        acc_wdata   = cap_wdata;
        acc_wmask   = cap_wmask;
        if (state == S_IDLE) begin
            acc_rw      = i_rw;
            acc_address = i_address;
            acc_wdata   = i_wdata;
            acc_wmask   = i_wmask;
        end
    end

    assign acc_idx = acc_address[IDX_W-1:0];

`ifdef BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
    assign acc_ok = ({1'b0, acc_address} < (ADDRESS_WIDTH + 1)'(SIZE));
`else
    // upper address bits are deliberately ignored so addresses wrap
    logic unused_address_bits;
    assign unused_address_bits = ^acc_address[ADDRESS_WIDTH-1:IDX_W];
    assign acc_ok = 1'b1;
`endif

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_request) begin
                    state_next = (LATENCY == 1) ? S_READY : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_request) begin
                    state_next = S_IDLE;
                end else if (count == 4'd1) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                state_next = i_request ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!i_request) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // READY is only ever entered from IDLE or WAIT, so this marks the commit edge
    assign enter_ready = (state_next == S_READY);
    // gating with i_reset keeps a request held during reset from writing the RAM
    assign mem_we      = enter_ready && i_reset && acc_rw && acc_ok;

    assign o_ready = (state == S_READY);
    assign o_busy  = (state != S_IDLE);

    // state register
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // transaction capture and latency countdown
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count       <= 4'd0;
            cap_rw      <= 1'b0;
            cap_address <= '0;
            cap_wdata   <= 32'h0;
            cap_wmask   <= 4'h0;
        end else if (state == S_IDLE && i_request) begin
            count       <= 4'(LATENCY - 1);
            cap_rw      <= i_rw;
            cap_address <= i_address;
            cap_wdata   <= i_wdata;
            cap_wmask   <= i_wmask;
        end else if (state == S_WAIT && i_request && count != 4'd1) begin
            count <= count - 4'd1;
        end
    end

    // byte-masked RAM write on the READY entry edge; contents survive reset
    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // read data register, only reloaded by a completing read
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_rdata <= 32'h0;
        end else if (enter_ready && !acc_rw) begin
            o_rdata <= acc_ok ? mem[acc_idx] : 32'h0;
        end
    end

`ifdef BUS_MEMORY_RESPONDER_RANGE_CHECK_EN
    logic err_q;

    // remember whether the completing transaction was out of range
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            err_q <= 1'b0;
        end else if (enter_ready) begin
            err_q <= !acc_ok;
        end
    end

    assign o_error = (state == S_READY) && err_q;
`endif

endmodule

// File: doc/bus_memory_responder.md
# bus_memory_responder

Synthesizable responder (target) end of the single-outstanding request/ready memory bus driven by the write buffer and the other bus initiators. It accepts one read or masked write at a time into an internal word-addressed RAM, acknowledges after a configurable latency with a one-cycle ready pulse, and waits for the initiator to release the request before it accepts another. It serves as the on-chip scratch RAM behind an initiator and as the bus-side model in initiator test benches.

## Interface
- SIZE, 1024: RAM depth in 32-bit words; power of two, ≥ 2.
- ADDRESS_WIDTH, 32: width of `i_address` (word address).
- LATENCY, 1: cycles from the acceptance edge to `o_ready` high; legal range 1..15.

Ports:
- i_clock  in  1  single clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_request  in  1  transaction request; held by the initiator until it sees `o_ready`.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  ADDRESS_WIDTH  word address.
- i_wdata  in  32  write data.
- i_wmask  in  4  byte enables; bit n enables byte n.
- o_ready  out  1  one-cycle completion pulse.
- o_rdata  out  32  read data; valid while `o_ready` is high.
- o_busy  out  1  high whenever the FSM is not in IDLE.
- o_error  out  1  present only with BUS_MEMORY_RESPONDER_RANGE_CHECK_EN.

## Operation
- FSM states: IDLE, WAIT, READY, RELEASE.
- IDLE: if `i_request` = 1 at an edge, capture `i_rw`, `i_address`, `i_wdata`, `i_wmask`, and load the 4-bit counter with LATENCY−1.
  - Go to READY if LATENCY = 1; otherwise go to WAIT.
- WAIT:
  - If `i_request` = 0, abandon the transaction with no RAM access and return to IDLE.
  - Else if counter = 1, go to READY. Otherwise decrement the counter.
- Entering READY, on the same edge:
  - Write: RAM bytes with mask bit set take the captured data. Mask 0000 completes normally with no change.
  - Read: `o_rdata` is loaded from the RAM.
- READY lasts exactly one cycle with `o_ready` = 1. Next state is IDLE if `i_request` = 0, else RELEASE.
- RELEASE: stay while `i_request` = 1; go to IDLE when it is 0.
  - Consequence: `o_ready` never asserts twice for one held request.
- Index = captured address[log2(SIZE)−1:0]. Upper address bits are ignored, so addresses wrap modulo SIZE (unless range check is enabled).
- `o_rdata` holds its last read value until the next read completes. Writes do not alter it.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- Request seen high at edge N → `o_ready` high for cycle N+LATENCY to N+LATENCY+1, for an uninterrupted request.
- The earliest next acceptance is the first edge at which `i_request` is sampled low, then high again. Minimum spacing is 1 low cycle.
- Reset (`i_reset` = 0) takes effect immediately and asynchronously:
  - state = IDLE; `o_ready`, `o_busy`, `o_error` = 0; `o_rdata` = 32'h0.
  - A write whose READY edge has not occurred is dropped.
- Reset in READY or RELEASE: the already-committed write remains in the RAM.
- After reset release, a request held high is accepted at the first edge with `i_reset` = 1.
- Request and reset release on the same edge: reset has priority at that edge.

## Configuration
- BUS_MEMORY_RESPONDER_RANGE_CHECK_EN defined:
  - An address ≥ SIZE still completes with the normal `o_ready` timing.
  - No RAM write is performed, and `o_rdata` = 32'h0 for reads.
  - `o_error` = 1 in the same cycle as `o_ready`, 0 otherwise.
- Not defined: the `o_error` port does not exist, and addresses wrap modulo SIZE.

## Test plan
- LATENCY=1: write 0x0003 / 0xb00b_3333 / mask 1111, then read 0x0003 → `o_ready` 1 cycle after each request; `o_rdata` = 0xb00b_3333.
- Write 0x0001 = 0xffff_ffff, then write 0x0001 = 0xb00b_1111 with mask 1010, then read 0x0001 → 0xb0ff_11ff.
- LATENCY=4, request held high for 10 cycles → exactly one `o_ready` pulse, 4 cycles after acceptance; `o_busy` high until the request drops.
- LATENCY=4: drop the request 2 cycles after acceptance of write 0x0005 = 0x5555_5555, then read 0x0005 → old value returned; no `o_ready` for the abandoned write.
- Assert reset during WAIT of write 0x0009 → `o_ready` = 0 immediately, state IDLE; a subsequent read of 0x0009 returns the pre-write contents.
- SIZE=1024 with the macro: write 0x0000_0400 = 0x1234_5678, then read 0x0000_0000 → `o_error` pulses with `o_ready` on the write; word 0 is unchanged. Without the macro, the same read returns 0x1234_5678.
